// File: rtl/div_pkg.sv
// Shared types and width helpers for the restoring divider.
// Default widths give an 8-by-4 bit unsigned divide.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in a dividend bit, conditionally subtract.
// Zero latency, no flow control.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_o
);

  localparam int RW = DIVISOR_W + 1;
  localparam int SW = DIVISOR_W + 2;

  logic [SW-1:0] shifted;
  logic [SW-1:0] dvs_ext;

  // R stays below the divisor between steps, so its MSB is always zero and the
  // wide shift only guards against truncation.
  assign shifted = {r_i, bit_i};
  assign dvs_ext = {2'b00, divisor_i};
  assign q_o     = (shifted >= dvs_ext);
  assign r_o     = RW'(q_o ? (shifted - dvs_ext) : shifted);

endmodule

// File: rtl/div_restoring.sv
// Iterative restoring divider, one quotient bit per cycle; start-to-done is DIVIDEND_W+1 cycles (1 for divide-by-zero).
// start is only sampled in IDLE; requests while busy are dropped, nothing is queued.
module div_restoring
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] div_a,
  input  logic [DIVISOR_W-1:0]  div_b,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] div_q,
  output logic [DIVISOR_W-1:0]  div_r,
  output logic                  div_zero
);

  localparam int              CNT_W   = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIVIDEND_W - 1);

  state_t state_q, state_d;

  logic [DIVIDEND_W-1:0] a_q;
  logic [DIVISOR_W-1:0]  b_q;
  logic [DIVISOR_W:0]    r_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic                  last_q;
  logic                  zero_q;
  logic [DIVIDEND_W-1:0] quo_out_q;
  logic [DIVISOR_W-1:0]  rem_out_q;
  logic                  dz_out_q;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_q;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (a_q[cnt_q]),
    .divisor_i(b_q),
    .r_o      (step_r),
    .q_o      (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == DONE);
    done = (state_q == DONE);
  end

  // A zero divisor rides through one CALC cycle with last_q already set, so
  // every result load happens on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= div_a;
            b_q    <= div_b;
            r_q    <= '0;
            cnt_q  <= CNT_TOP;
            quo_q  <= '0;
            zero_q <= (div_b == '0);
            last_q <= (div_b == '0);
          end
        end
        CALC: begin
          if (last_q) begin
            quo_out_q <= zero_q ? '1 : quo_q;
            rem_out_q <= zero_q ? '0 : r_q[DIVISOR_W-1:0];
            dz_out_q  <= zero_q;
            last_q    <= 1'b0;
          end else begin
            r_q   <= step_r;
            quo_q <= {quo_q[DIVIDEND_W-2:0], step_q};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) last_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_q    = quo_out_q;
  assign div_r    = rem_out_q;
  assign div_zero = dz_out_q;

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring against an arithmetic reference (/ and %).
// Directed scenarios plus an exhaustive sweep and a random batch.
module tb_div_restoring;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] div_a;
  logic [3:0] div_b;
  logic       busy;
  logic       done;
  logic [7:0] div_q;
  logic [3:0] div_r;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  div_restoring dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .div_a   (div_a),
    .div_b   (div_b),
    .busy    (busy),
    .done    (done),
    .div_q   (div_q),
    .div_r   (div_r),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected it to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full division from IDLE, checked against plain arithmetic.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input string tag);
    int ai, bi, eq, er, ez, elat, lat, bcnt;
    logic [7:0] gq;
    logic [3:0] gr;
    logic       gz;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      eq = 255; er = 0; ez = 1; elat = 1;
    end else begin
      eq = ai / bi; er = ai % bi; ez = 0; elat = 9;
    end
    start = 1'b1;
    div_a = a;
    div_b = b;
    tick();
    start = 1'b0;
    div_a = 8'($urandom);
    div_b = 4'($urandom);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    if (busy === 1'b1) bcnt++;
    gq = div_q; gr = div_r; gz = div_zero;
    chk({tag, "_lat"},  32'(lat),  32'(elat));
    chk({tag, "_busy"}, 32'(bcnt), 32'(elat + 1));
    chk({tag, "_q"},    32'(gq),   32'(eq));
    chk({tag, "_r"},    32'(gr),   32'(er));
    chk({tag, "_zero"}, 32'(gz),   32'(ez));
    if (bi != 0) begin
      chk({tag, "_inv"},  32'(int'(gq) * bi + int'(gr)), 32'(ai));
      chk({tag, "_rltb"}, 32'(int'(gr) < bi), 32'd1);
    end
    tick();
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int dcnt, last_t;
    logic [7:0] ra;
    logic [3:0] rb;

    rst = 1'b1; start = 1'b0; div_a = '0; div_b = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(div_q), 32'd0);
    chk("rst_r",    32'(div_r), 32'd0);
    chk("rst_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;
    tick();

    do_div(8'd100, 4'd7, "d100_7");
    do_div(8'd255, 4'd1, "d255_1");
    do_div(8'd5,   4'd9, "d5_9");
    do_div(8'd42,  4'd0, "dz42");
    do_div(8'd42,  4'd6, "d42_6");

    // start pulses while a division is in flight must be dropped
    start = 1'b1; div_a = 8'd100; div_b = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; div_a = 8'd200; div_b = 4'd3;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        dcnt++;
        chk("ign_q", 32'(div_q), 32'd14);
        chk("ign_r", 32'(div_r), 32'd2);
      end
      tick();
    end
    chk("ign_dones", 32'(dcnt), 32'd1);

    // synchronous reset in the middle of CALC
    start = 1'b1; div_a = 8'd100; div_b = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs", 32'({busy, done, div_zero}), 32'd0);
    chk("abort_q",    32'(div_q), 32'd0);
    chk("abort_r",    32'(div_r), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    chk("abort_nodone", 32'(dcnt), 32'd0);
    do_div(8'd9, 4'd2, "d9_2");

    // start held high: busy 10 cycles plus one IDLE cycle per operation
    start = 1'b1; div_a = 8'd60; div_b = 4'd4;
    dcnt = 0; last_t = -1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (done === 1'b1) begin
        dcnt++;
        chk("held_q", 32'(div_q), 32'd15);
        chk("held_r", 32'(div_r), 32'd0);
        if (last_t >= 0) chk("held_period", 32'(t - last_t), 32'd11);
        last_t = t;
      end
    end
    start = 1'b0;
    chk("held_dones", 32'(dcnt), 32'd4);
    for (int i = 0; i < 14; i++) tick();

    // exhaustive sweep of nonzero divisors
    for (int b = 1; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        do_div(8'(a), 4'(b), "sweep");
      end
    end

    // random operands including zero divisors
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
      do_div(ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
